// File: rtl/fma16_vec_checker.sv
// fma16_vec_checker
// Test-vector sequencer/checker for the combinational fma16 half-precision
// FMA unit. Accepts one vector per valid/ready handshake. Holds the operands
// and controls on the fma16 inputs for SETTLE extra cycles. Compares
// result (and optionally flags) against the expected values. Keeps
// saturating vector/error counters and captures the first mismatch.
//
// Build option: define FMA16_CHK_FLAGS_EN to include flags in the compare.
//
// Ports:
//   i_clk, i_reset_n        clock, async active-low reset
//   i_clear                 sync clear of counters / first-error capture
//   i_vec_valid/o_vec_ready vector handshake
//   i_vec_x/y/z, i_vec_ctrl operands, {mul,add,negp,negz,roundmode[1:0]}
//   i_vec_exp_result/flags  expected result and {nv,of,uf,nx}
//   o_x/y/z, o_mul, o_add, o_negp, o_negz, o_roundmode  to fma16
//   i_result, i_flags       from fma16
//   o_err_pulse             one-cycle pulse per mismatch
//   o_vec_count/o_err_count saturating counters
//   o_first_err_*           capture of the first failing vector
module fma16_vec_checker #(
    parameter int SETTLE  = 1,
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_vec_valid,
    output logic               o_vec_ready,
    input  logic [15:0]        i_vec_x,
    input  logic [15:0]        i_vec_y,
    input  logic [15:0]        i_vec_z,
    input  logic [5:0]         i_vec_ctrl,
    input  logic [15:0]        i_vec_exp_result,
    input  logic [3:0]         i_vec_exp_flags,
    output logic [15:0]        o_x,
    output logic [15:0]        o_y,
    output logic [15:0]        o_z,
    output logic               o_mul,
    output logic               o_add,
    output logic               o_negp,
    output logic               o_negz,
    output logic [1:0]         o_roundmode,
    input  logic [15:0]        i_result,
    input  logic [3:0]         i_flags,
    output logic               o_err_pulse,
    output logic [COUNT_W-1:0] o_vec_count,
    output logic [COUNT_W-1:0] o_err_count,
    output logic               o_first_err_valid,
    output logic [COUNT_W-1:0] o_first_err_index,
    output logic [15:0]        o_first_err_result,
    output logic [3:0]         o_first_err_flags
);

`ifdef FMA16_CHK_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

    state_t             r_state;
    logic [3:0]         r_settle;
    logic               r_ready;
    logic [15:0]        r_x, r_y, r_z;
    logic [5:0]         r_ctrl;
    logic [15:0]        r_exp_result;
    logic [3:0]         r_exp_flags;
    logic               r_err_pulse;
    logic [COUNT_W-1:0] r_vec_count;
    logic [COUNT_W-1:0] r_err_count;
    logic               r_fe_valid;
    logic [COUNT_W-1:0] r_fe_index;
    logic [15:0]        r_fe_result;
    logic [3:0]         r_fe_flags;

    // Flags term is masked off when the flags check is not built in.
    logic w_mismatch;
    assign w_mismatch = (i_result != r_exp_result) |
                        (FLAGS_EN & (i_flags != r_exp_flags));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_settle     <= '0;
            r_ready      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_ctrl       <= '0;
            r_exp_result <= '0;
            r_exp_flags  <= '0;
            r_err_pulse  <= 1'b0;
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_fe_valid   <= 1'b0;
            r_fe_index   <= '0;
            r_fe_result  <= '0;
            r_fe_flags   <= '0;
        end else if (i_clear) begin
            // Clear beats any coincident compare or handshake; DUT port
            // registers keep their last vector.
            r_state     <= IDLE;
            r_settle    <= '0;
            r_ready     <= 1'b0;
            r_err_pulse <= 1'b0;
            r_vec_count <= '0;
            r_err_count <= '0;
            r_fe_valid  <= 1'b0;
            r_fe_index  <= '0;
            r_fe_result <= '0;
            r_fe_flags  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (i_vec_valid && r_ready) begin
                        r_x          <= i_vec_x;
                        r_y          <= i_vec_y;
                        r_z          <= i_vec_z;
                        r_ctrl       <= i_vec_ctrl;
                        r_exp_result <= i_vec_exp_result;
                        r_exp_flags  <= i_vec_exp_flags;
                        r_settle     <= 4'(SETTLE);
                        r_ready      <= 1'b0;
                        r_state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_settle != 4'd0) begin
                        r_settle <= r_settle - 4'd1;
                    end else begin
                        if (r_vec_count != CNT_MAX)
                            r_vec_count <= r_vec_count + 1'b1;
                        if (w_mismatch) begin
                            r_err_pulse <= 1'b1;
                            if (r_err_count != CNT_MAX)
                                r_err_count <= r_err_count + 1'b1;
                            if (!r_fe_valid) begin
                                r_fe_valid  <= 1'b1;
                                r_fe_index  <= r_vec_count;
                                r_fe_result <= i_result;
                                r_fe_flags  <= i_flags;
                            end
                        end
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_vec_ready        = r_ready;
    assign o_x                = r_x;
    assign o_y                = r_y;
    assign o_z                = r_z;
    assign o_mul              = r_ctrl[5];
    assign o_add              = r_ctrl[4];
    assign o_negp             = r_ctrl[3];
    assign o_negz             = r_ctrl[2];
    assign o_roundmode        = r_ctrl[1:0];
    assign o_err_pulse        = r_err_pulse;
    assign o_vec_count        = r_vec_count;
    assign o_err_count        = r_err_count;
    assign o_first_err_valid  = r_fe_valid;
    assign o_first_err_index  = r_fe_index;
    assign o_first_err_result = r_fe_result;
    assign o_first_err_flags  = r_fe_flags;

endmodule

// File: tb/tb_fma16_vec_checker.sv
// Bench for fma16_vec_checker. Two instances (COUNT_W=16 and COUNT_W=4)
// share stimulus and fma16 model outputs; a count-based model (totals since
// last clear, saturated on read) predicts every observable output.
module tb_fma16_vec_checker;

    localparam int SETTLE = 1;
`ifdef FMA16_CHK_FLAGS_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, clear, vec_valid;
    logic [15:0] vec_x, vec_y, vec_z, vec_er, result;
    logic [5:0]  vec_ctrl;
    logic [3:0]  vec_ef, flags;

    logic        rdy_a, rdy_b, mul_a, mul_b, add_a, add_b, np_a, np_b, nz_a, nz_b;
    logic [15:0] x_a, y_a, z_a, x_b, y_b, z_b, fer_a, fer_b;
    logic [1:0]  rm_a, rm_b;
    logic        ep_a, ep_b, fev_a, fev_b;
    logic [15:0] vc_a, ec_a, fei_a;
    logic [3:0]  vc_b, ec_b, fei_b, fef_a, fef_b;

    always #5 clk = ~clk;

    fma16_vec_checker #(.SETTLE(SETTLE), .COUNT_W(16)) dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_clear(clear),
        .i_vec_valid(vec_valid), .o_vec_ready(rdy_a),
        .i_vec_x(vec_x), .i_vec_y(vec_y), .i_vec_z(vec_z), .i_vec_ctrl(vec_ctrl),
        .i_vec_exp_result(vec_er), .i_vec_exp_flags(vec_ef),
        .o_x(x_a), .o_y(y_a), .o_z(z_a), .o_mul(mul_a), .o_add(add_a),
        .o_negp(np_a), .o_negz(nz_a), .o_roundmode(rm_a),
        .i_result(result), .i_flags(flags), .o_err_pulse(ep_a),
        .o_vec_count(vc_a), .o_err_count(ec_a), .o_first_err_valid(fev_a),
        .o_first_err_index(fei_a), .o_first_err_result(fer_a),
        .o_first_err_flags(fef_a));

    fma16_vec_checker #(.SETTLE(SETTLE), .COUNT_W(4)) dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_clear(clear),
        .i_vec_valid(vec_valid), .o_vec_ready(rdy_b),
        .i_vec_x(vec_x), .i_vec_y(vec_y), .i_vec_z(vec_z), .i_vec_ctrl(vec_ctrl),
        .i_vec_exp_result(vec_er), .i_vec_exp_flags(vec_ef),
        .o_x(x_b), .o_y(y_b), .o_z(z_b), .o_mul(mul_b), .o_add(add_b),
        .o_negp(np_b), .o_negz(nz_b), .o_roundmode(rm_b),
        .i_result(result), .i_flags(flags), .o_err_pulse(ep_b),
        .o_vec_count(vc_b), .o_err_count(ec_b), .o_first_err_valid(fev_b),
        .o_first_err_index(fei_b), .o_first_err_result(fer_b),
        .o_first_err_flags(fef_b));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: totals since the last clear/reset.
    int unsigned m_vec, m_err, m_fei;
    bit          m_fev;
    logic [15:0] m_fer;
    logic [3:0]  m_fef;

    function automatic int unsigned sat(int unsigned v, int w);
        int unsigned mx = (32'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_vec = 0; m_err = 0; m_fei = 0; m_fev = 0; m_fer = '0; m_fef = '0;
    endtask

    task automatic model_compare(input logic [15:0] er, input logic [3:0] ef,
                                 input logic [15:0] mr, input logic [3:0] mf,
                                 output bit mism);
        mism = (mr != er) || (FEN && (mf != ef));
        if (mism) begin
            m_err++;
            if (!m_fev) begin
                m_fev = 1; m_fei = m_vec; m_fer = mr; m_fef = mf;
            end
        end
        m_vec++;
    endtask

    task automatic check_counts(string tag);
        chk({tag, "_vc16"},  32'(vc_a),  sat(m_vec, 16));
        chk({tag, "_ec16"},  32'(ec_a),  sat(m_err, 16));
        chk({tag, "_fev16"}, 32'(fev_a), 32'(m_fev));
        chk({tag, "_fei16"}, 32'(fei_a), sat(m_fei, 16));
        chk({tag, "_fer16"}, 32'(fer_a), 32'(m_fer));
        chk({tag, "_fef16"}, 32'(fef_a), 32'(m_fef));
        chk({tag, "_vc4"},   32'(vc_b),  sat(m_vec, 4));
        chk({tag, "_ec4"},   32'(ec_b),  sat(m_err, 4));
        chk({tag, "_fev4"},  32'(fev_b), 32'(m_fev));
        chk({tag, "_fei4"},  32'(fei_b), sat(m_fei, 4));
        chk({tag, "_fer4"},  32'(fer_b), 32'(m_fer));
    endtask

    task automatic drive_vec(input logic [15:0] vx, vy, vz, input logic [5:0] vc,
                             input logic [15:0] er, input logic [3:0] ef,
                             input logic [15:0] mr, input logic [3:0] mf);
        vec_x = vx; vec_y = vy; vec_z = vz; vec_ctrl = vc;
        vec_er = er; vec_ef = ef; result = mr; flags = mf;
    endtask

    // One full vector: handshake, port check, settle, compare, pulse width.
    task automatic run_vec(string tag, input logic [15:0] vx, vy, vz,
                           input logic [5:0] vc, input logic [15:0] er,
                           input logic [3:0] ef, input logic [15:0] mr,
                           input logic [3:0] mf);
        int w = 0;
        bit mism;
        drive_vec(vx, vy, vz, vc, er, ef, mr, mf);
        vec_valid = 1'b1;
        while (!rdy_a && w < 20) begin tick(); w++; end
        chk({tag, "_ready_wait"}, 32'(rdy_a), 32'd1);
        tick();
        vec_valid = 1'b0;
        chk({tag, "_ports_a"}, {x_a, y_a}, {vx, vy});
        chk({tag, "_ports_b"}, {x_b, y_b}, {vx, vy});
        chk({tag, "_z_ctrl"}, {10'd0, z_a, mul_a, add_a, np_a, nz_a, rm_a}, {10'd0, vz, vc});
        chk({tag, "_busy"}, {rdy_a, rdy_b}, 2'b00);
        for (int i = 0; i < SETTLE + 1; i++) begin
            chk({tag, "_nopulse"}, {ep_a, ep_b}, 2'b00);
            tick();
        end
        model_compare(er, ef, mr, mf, mism);
        chk({tag, "_ready_back"}, {rdy_a, rdy_b}, 2'b11);
        chk({tag, "_pulse"}, {ep_a, ep_b}, {mism, mism});
        check_counts(tag);
        tick();
        chk({tag, "_pulse_end"}, {ep_a, ep_b}, 2'b00);
    endtask

    task automatic do_clear(string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        chk({tag, "_ready0"}, {rdy_a, rdy_b}, 2'b00);
        chk({tag, "_pulse0"}, {ep_a, ep_b}, 2'b00);
        check_counts(tag);
        tick();
        chk({tag, "_ready1"}, {rdy_a, rdy_b}, 2'b11);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; vec_valid = 1'b0;
        drive_vec('0, '0, '0, '0, '0, '0, '0, '0);
        model_reset();

        // Reset state and release
        repeat (3) tick();
        chk("rst_ready", {rdy_a, rdy_b}, 2'b00);
        chk("rst_ports", {x_a, y_a}, 32'd0);
        chk("rst_ctrl", {z_a, mul_a, add_a, np_a, nz_a, rm_a, ep_a}, 23'd0);
        check_counts("rst");
        reset_n = 1'b1;
        chk("rel_ready_still0", {rdy_a, rdy_b}, 2'b00);
        tick();
        chk("rel_ready1", {rdy_a, rdy_b}, 2'b11);
        check_counts("rel");

        // Basic passing vector: 1.0*1.0+0 = 1.0
        run_vec("pass", 16'h3C00, 16'h3C00, 16'h0000, 6'b110000,
                16'h3C00, 4'b0000, 16'h3C00, 4'b0000);

        // First-error capture at index 2 of 3, later failure leaves it alone
        do_clear("clr1");
        run_vec("v0", 16'h3C00, 16'h3C00, 16'h0000, 6'b110000, 16'h3C00, 4'h0, 16'h3C00, 4'h0);
        run_vec("v1", 16'h4000, 16'h3C00, 16'h0000, 6'b110001, 16'h4000, 4'h0, 16'h4000, 4'h0);
        run_vec("v2", 16'h3C00, 16'h3C00, 16'h0000, 6'b110000, 16'h4000, 4'h0, 16'h3C00, 4'h1);
        chk("fe_index2", 32'(fei_a), 32'd2);
        chk("fe_result", 32'(fer_a), 32'h3C00);
        run_vec("v3", 16'h1234, 16'h5678, 16'h9ABC, 6'b101110, 16'h1111, 4'h0, 16'h2222, 4'h8);
        chk("fe_hold_idx", 32'(fei_a), 32'd2);
        chk("fe_err2", 32'(ec_a), 32'd2);

        // Flags-only mismatch
        do_clear("clr2");
        run_vec("flg", 16'h3C00, 16'h3C00, 16'h0000, 6'b110000, 16'h3C00, 4'b0001, 16'h3C00, 4'b0000);
        chk("flg_err", 32'(ec_a), FEN ? 32'd1 : 32'd0);

        // Randomised vectors, roughly half mismatching
        for (int k = 0; k < 12; k++) begin
            logic [15:0] rx, ry, rz, rer, rmr;
            logic [5:0]  rc;
            logic [3:0]  ref_, rmf;
            rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
            rc = 6'($urandom); rer = 16'($urandom); ref_ = 4'($urandom);
            rmr = ($urandom_range(0, 1) == 0) ? rer : 16'($urandom);
            rmf = ($urandom_range(0, 1) == 0) ? ref_ : 4'($urandom);
            run_vec("rnd", rx, ry, rz, rc, rer, ref_, rmr, rmf);
        end

        // Saturation with vec_valid held high
        do_clear("clr3");
        begin
            int na = 0, cyc = 0, last = 0;
            bit r;
            drive_vec(16'h0001, 16'h0002, 16'h0003, 6'b010011, 16'h7C00, 4'h0, 16'h0000, 4'h2);
            vec_valid = 1'b1;
            while (na < 20 && cyc < 1000) begin
                r = rdy_a;
                tick();
                cyc++;
                if (r) begin
                    if (na > 0) chk("sat_spacing", 32'(cyc - last), 32'(SETTLE + 2));
                    last = cyc;
                    na++;
                end
            end
            chk("sat_accepts", 32'(na), 32'd20);
            vec_valid = 1'b0;
            repeat (SETTLE + 1) tick();
            for (int k = 0; k < 20; k++) begin
                bit mm;
                model_compare(16'h7C00, 4'h0, 16'h0000, 4'h2, mm);
            end
            check_counts("sat");
            chk("sat_vc4", 32'(vc_b), 32'd15);
            chk("sat_ec4", 32'(ec_b), 32'd15);
        end

        // Clear on the compare edge, then reset mid-DRIVE
        do_clear("clr4");
        begin
            int w = 0;
            drive_vec(16'hAAAA, 16'h5555, 16'h0F0F, 6'b111111, 16'h1234, 4'h0, 16'h4321, 4'h0);
            vec_valid = 1'b1;
            while (!rdy_a && w < 20) begin tick(); w++; end
            tick();
            vec_valid = 1'b0;
            repeat (SETTLE) tick();
            clear = 1'b1;
            tick();
            clear = 1'b0;
            chk("cc_pulse", {ep_a, ep_b}, 2'b00);
            chk("cc_ready0", {rdy_a, rdy_b}, 2'b00);
            check_counts("cc");
            tick();
            chk("cc_ready1", {rdy_a, rdy_b}, 2'b11);
            vec_valid = 1'b1;
            tick();
            vec_valid = 1'b0;
            chk("rd_drive", 32'(x_a), 32'hAAAA);
            #2 reset_n = 1'b0;
            #1;
            chk("rd_ports0", {x_a, y_a}, 32'd0);
            chk("rd_ready0", {rdy_a, rdy_b}, 2'b00);
            check_counts("rd");
            reset_n = 1'b1;
            for (int i = 0; i < SETTLE + 3; i++) begin
                tick();
                chk("rd_nopulse", {ep_a, ep_b}, 2'b00);
            end
            check_counts("rd_after");
            run_vec("post", 16'h3C00, 16'h4000, 16'h3C00, 6'b110000, 16'h4200, 4'h0, 16'h4200, 4'h0);
            chk("post_vc", 32'(vc_a), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
